// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: VGA timing generator and pong frame renderer on the pixel clock.
// Game inputs are sampled once per frame at vblank start (h_cnt==0, v_cnt==V_ACTIVE) and
// frame_tick pulses the cycle after, telling the engine it may move objects again.
// Optional feature macro: SCORE_DISPLAY_EN draws the latched score as two hex digits.
module pong_vga_renderer #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int BALL_SIZE     = 10,
    parameter int PADDLE_WIDTH  = 10,
    parameter int PADDLE_HEIGHT = 60,
    parameter int PLAYER_X      = 20,
    parameter int OPP_X         = 610
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] player_paddle_y,
    input  logic [9:0] opponent_paddle_y,
    input  logic [9:0] current_ball_x,
    input  logic [9:0] current_ball_y,
    input  logic [7:0] score,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] red,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_LATCH    = 10'(V_ACTIVE);
    localparam logic [10:0] H_ACT_W    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H_W    = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] PLAYER_L   = 11'(PLAYER_X);
    localparam logic [10:0] PLAYER_R   = 11'(PLAYER_X + PADDLE_WIDTH);
    localparam logic [10:0] OPP_L      = 11'(OPP_X);
    localparam logic [10:0] OPP_R      = 11'(OPP_X + PADDLE_WIDTH);
    localparam logic [10:0] NET_LEFT   = 11'd318;
    localparam logic [10:0] NET_RIGHT  = 11'd321;

    localparam logic [5:0] COL_BLACK  = 6'b00_00_00;
    localparam logic [5:0] COL_WHITE  = 6'b11_11_11;
    localparam logic [5:0] COL_PLAYER = 6'b00_11_00;
    localparam logic [5:0] COL_OPP    = 6'b11_00_00;
    localparam logic [5:0] COL_NET    = 6'b01_01_01;

    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [9:0]  player_y_r;
    logic [9:0]  opp_y_r;
    logic [9:0]  ball_x_r;
    logic [9:0]  ball_y_r;
    logic [10:0] x_s;
    logic [10:0] y_s;
    logic        active_s;
    logic        ball_hit_s;
    logic        player_hit_s;
    logic        opp_hit_s;
    logic        net_hit_s;
    logic        glyph_hit_s;
    logic [5:0]  rgb_s;

    // All object tests are done 11 bits wide so pos+size never wraps back onto the screen.
    assign x_s = {1'b0, h_cnt_r};
    assign y_s = {1'b0, v_cnt_r};

    // Raster position: h runs 0..H_TOTAL-1, v advances at end of each line and wraps at end of frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

`ifdef SCORE_DISPLAY_EN
    logic [7:0]  score_r;
    logic        in_player_digit_s;
    logic        in_opp_digit_s;
    logic        in_digit_rows_s;
    logic [10:0] glyph_base_s;
    logic [3:0]  digit_s;
    logic [1:0]  col_s;
    logic [2:0]  row_s;
    logic [3:0]  idx_s;
    logic [14:0] glyph_bits_s;

    // 3x5 hex font, row 0 in bits 14:12, leftmost column in the MSB of each row.
    function automatic logic [14:0] glyph_rom(input logic [3:0] digit);
        case (digit)
            4'h0:    glyph_rom = 15'b111_101_101_101_111;
            4'h1:    glyph_rom = 15'b010_110_010_010_111;
            4'h2:    glyph_rom = 15'b111_001_111_100_111;
            4'h3:    glyph_rom = 15'b111_001_111_001_111;
            4'h4:    glyph_rom = 15'b101_101_111_001_001;
            4'h5:    glyph_rom = 15'b111_100_111_001_111;
            4'h6:    glyph_rom = 15'b111_100_111_101_111;
            4'h7:    glyph_rom = 15'b111_001_001_001_001;
            4'h8:    glyph_rom = 15'b111_101_111_101_111;
            4'h9:    glyph_rom = 15'b111_101_111_001_111;
            4'hA:    glyph_rom = 15'b010_101_111_101_101;
            4'hB:    glyph_rom = 15'b110_101_110_101_110;
            4'hC:    glyph_rom = 15'b111_100_100_100_111;
            4'hD:    glyph_rom = 15'b110_101_101_101_110;
            4'hE:    glyph_rom = 15'b111_100_111_100_111;
            4'hF:    glyph_rom = 15'b111_100_111_100_100;
            default: glyph_rom = 15'b000_000_000_000_000;
        endcase
    endfunction

    // Score is sampled together with the positions so the digits cannot tear mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_r <= 8'd0;
        end else if ((h_cnt_r == 10'd0) && (v_cnt_r == V_LATCH)) begin
            score_r <= score;
        end
    end

    // Map the pixel into a 4x4-px font cell of the player (left) or opponent (right) digit.
    always_comb begin
        in_player_digit_s = (x_s >= 11'd292) && (x_s <= 11'd303);
        in_opp_digit_s    = (x_s >= 11'd336) && (x_s <= 11'd347);
        in_digit_rows_s   = (y_s >= 11'd16) && (y_s <= 11'd35);
        if (in_player_digit_s) begin
            glyph_base_s = 11'd292;
            digit_s      = score_r[3:0];
        end else begin
            glyph_base_s = 11'd336;
            digit_s      = score_r[7:4];
        end
        col_s        = 2'((x_s - glyph_base_s) >> 2'd2);
        row_s        = 3'((y_s - 11'd16) >> 2'd2);
        idx_s        = ({1'b0, row_s} * 4'd3) + {2'b00, col_s};
        glyph_bits_s = glyph_rom(digit_s);
        if (in_digit_rows_s && (in_player_digit_s || in_opp_digit_s)) begin
            glyph_hit_s = glyph_bits_s[4'd14 - idx_s];
        end else begin
            glyph_hit_s = 1'b0;
        end
    end
`else
    logic unused_score_s;

    assign unused_score_s = ^score;
    assign glyph_hit_s    = 1'b0;
`endif

    // Sample the engine's positions at vblank start and announce the sample with frame_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_y_r <= 10'd210;
            opp_y_r    <= 10'd210;
            ball_x_r   <= 10'd320;
            ball_y_r   <= 10'd240;
            frame_tick <= 1'b0;
        end else if ((h_cnt_r == 10'd0) && (v_cnt_r == V_LATCH)) begin
            player_y_r <= player_paddle_y;
            opp_y_r    <= opponent_paddle_y;
            ball_x_r   <= current_ball_x;
            ball_y_r   <= current_ball_y;
            frame_tick <= 1'b1;
        end else begin
            frame_tick <= 1'b0;
        end
    end

    // Classify the current pixel against each object and pick the highest-priority colour.
    always_comb begin
        active_s     = (x_s < H_ACT_W) && (y_s < V_ACT_W);
        ball_hit_s   = (x_s >= {1'b0, ball_x_r}) && (x_s < ({1'b0, ball_x_r} + BALL_W)) &&
                       (y_s >= {1'b0, ball_y_r}) && (y_s < ({1'b0, ball_y_r} + BALL_W));
        player_hit_s = (x_s >= PLAYER_L) && (x_s < PLAYER_R) &&
                       (y_s >= {1'b0, player_y_r}) && (y_s < ({1'b0, player_y_r} + PAD_H_W));
        opp_hit_s    = (x_s >= OPP_L) && (x_s < OPP_R) &&
                       (y_s >= {1'b0, opp_y_r}) && (y_s < ({1'b0, opp_y_r} + PAD_H_W));
        net_hit_s    = (x_s >= NET_LEFT) && (x_s <= NET_RIGHT) && (v_cnt_r[4] == 1'b0);
        if (!active_s) begin
            rgb_s = COL_BLACK;
        end else if (ball_hit_s) begin
            rgb_s = COL_WHITE;
        end else if (glyph_hit_s) begin
            rgb_s = COL_WHITE;
        end else if (player_hit_s) begin
            rgb_s = COL_PLAYER;
        end else if (opp_hit_s) begin
            rgb_s = COL_OPP;
        end else if (net_hit_s) begin
            rgb_s = COL_NET;
        end else begin
            rgb_s = COL_BLACK;
        end
    end

    // Register syncs and colour together so every video output lags the counters by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= 2'd0;
            green <= 2'd0;
            blue  <= 2'd0;
        end else begin
            hsync <= !((x_s >= HS_FIRST) && (x_s <= HS_LAST));
            vsync <= !((y_s >= VS_FIRST) && (y_s <= VS_LAST));
            red   <= rgb_s[5:4];
            green <= rgb_s[3:2];
            blue  <= rgb_s[1:0];
        end
    end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer: bench for pong_vga_renderer.
// A shrunken-timing instance is checked cycle by cycle against a position/rule model; a
// default-parameter instance pins the full 800-clock line timing over its first lines.
module tb_pong_vga_renderer;
    localparam int HA = 352, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 64, VFP = 2, VS = 2, VBP = 2;
    localparam int LINE = HA + HFP + HS + HBP;
    localparam int V_LINES = VA + VFP + VS + VBP;
    localparam int FRAME_CYC = LINE * V_LINES;
    localparam int BALL = 10, PW = 10, PH = 60, PLX = 20, OPPX = 330;

`ifdef SCORE_DISPLAY_EN
    localparam logic [14:0] FONT [16] = '{
        15'b111_101_101_101_111, 15'b010_110_010_010_111, 15'b111_001_111_100_111,
        15'b111_001_111_001_111, 15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001, 15'b111_101_111_101_111,
        15'b111_101_111_001_111, 15'b010_101_111_101_101, 15'b110_101_110_101_110,
        15'b111_100_100_100_111, 15'b110_101_101_101_110, 15'b111_100_111_100_111,
        15'b111_100_111_100_100};
    localparam logic [5:0] GLYPH_ON = 6'h3F;
`else
    localparam logic [5:0] GLYPH_ON = 6'h00;
`endif

    logic       clk;
    logic       rst;
    logic [9:0] player_paddle_y, opponent_paddle_y, current_ball_x, current_ball_y;
    logic [7:0] score;
    logic       hsync, vsync, frame_tick;
    logic [1:0] red, green, blue;
    logic       hsync_f, vsync_f, frame_tick_f;
    logic [1:0] red_f, green_f, blue_f;

    int n_checks = 0;
    int n_fail = 0;
    int k = 0;
    int tick_count = 0;
    bit model_started = 1'b0;
    int m_bx, m_by, m_py, m_oy, m_sc;
    logic       exp_hs, exp_vs, exp_ft;
    logic [5:0] exp_rgb;

    pong_vga_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .BALL_SIZE(BALL), .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH),
        .PLAYER_X(PLX), .OPP_X(OPPX)
    ) dut (
        .clk(clk), .rst(rst),
        .player_paddle_y(player_paddle_y), .opponent_paddle_y(opponent_paddle_y),
        .current_ball_x(current_ball_x), .current_ball_y(current_ball_y), .score(score),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_tick(frame_tick)
    );

    pong_vga_renderer dut_full (
        .clk(clk), .rst(rst),
        .player_paddle_y(player_paddle_y), .opponent_paddle_y(opponent_paddle_y),
        .current_ball_x(current_ball_x), .current_ball_y(current_ball_y), .score(score),
        .hsync(hsync_f), .vsync(vsync_f), .red(red_f), .green(green_f), .blue(blue_f),
        .frame_tick(frame_tick_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (k=%0d)", name, act, req, k);
        end
    endtask

    // Expected colour of a visible pixel from the drawing rules, plain integer geometry.
    function automatic logic [5:0] exp_pixel(input int x, input int y, input int bx, input int by,
                                             input int py, input int oy, input int sc);
`ifdef SCORE_DISPLAY_EN
        int d, ox, row, col;
        logic [14:0] g;
`endif
        if (x >= HA || y >= VA) return 6'h00;
        if (x >= bx && x < bx + BALL && y >= by && y < by + BALL) return 6'h3F;
`ifdef SCORE_DISPLAY_EN
        if (y >= 16 && y <= 35 && ((x >= 292 && x <= 303) || (x >= 336 && x <= 347))) begin
            if (x <= 303) begin d = sc % 16; ox = 292; end
            else begin d = sc / 16; ox = 336; end
            row = (y - 16) / 4;
            col = (x - ox) / 4;
            g = FONT[d];
            if (g[14 - (row * 3 + col)]) return 6'h3F;
        end
`else
        if (sc < 0) return 6'h00;
`endif
        if (x >= PLX && x < PLX + PW && y >= py && y < py + PH) return 6'h0C;
        if (x >= OPPX && x < OPPX + PW && y >= oy && y < oy + PH) return 6'h30;
        if (x >= 318 && x <= 321 && ((y / 16) % 2) == 0) return 6'h15;
        return 6'h00;
    endfunction

    // Model: k counts clocks since the raster origin; each edge renders position k.
    always @(posedge clk) begin : model
        int x, y;
        model_started = 1'b1;
        if (rst) begin
            k = 0;
            m_bx = 320; m_by = 240; m_py = 210; m_oy = 210; m_sc = 0;
            exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 6'h00; exp_ft = 1'b0;
        end else begin
            x = k % LINE;
            y = (k / LINE) % V_LINES;
            exp_rgb = exp_pixel(x, y, m_bx, m_by, m_py, m_oy, m_sc);
            exp_hs = !(x >= HA + HFP && x < HA + HFP + HS);
            exp_vs = !(y >= VA + VFP && y < VA + VFP + VS);
            exp_ft = (x == 0 && y == VA);
            if (exp_ft) begin
                m_bx = int'(current_ball_x); m_by = int'(current_ball_y);
                m_py = int'(player_paddle_y); m_oy = int'(opponent_paddle_y);
                m_sc = int'(score);
            end
            k = k + 1;
        end
    end

    // Every cycle: compare the shrunken instance against the model.
    always @(negedge clk) begin
        if (model_started) begin
            chk("hsync", 32'(hsync), 32'(exp_hs));
            chk("vsync", 32'(vsync), 32'(exp_vs));
            chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
            chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
            if (frame_tick === 1'b1) tick_count++;
        end
    end

    task automatic wait_k(input int t);
        int n = 0;
        while (k != t && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (k != t) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_k: reached k=%0d required k=%0d", k, t);
        end
    endtask

    // Return at the negedge where outputs show pixel (x,y) of frame f.
    task automatic goto(input int f, input int x, input int y);
        wait_k(f * FRAME_CYC + y * LINE + x + 1);
    endtask

    task automatic pix(input string name, input logic [5:0] req);
        chk(name, 32'({red, green, blue}), 32'(req));
    endtask

    initial begin
        rst = 1'b1;
        player_paddle_y = 10'd0;
        opponent_paddle_y = 10'd4;
        current_ball_x = 10'd100;
        current_ball_y = 10'd50;
        score = 8'h3A;
        repeat (3) @(negedge clk);
        chk("full_reset_hsync", 32'(hsync_f), 32'd1);
        chk("full_reset_vsync", 32'(vsync_f), 32'd1);
        chk("full_reset_rgb", 32'({red_f, green_f, blue_f}), 32'd0);
        chk("full_reset_tick", 32'(frame_tick_f), 32'd0);
        rst = 1'b0;

        // Full-size timing: net at 318 on line 0, hsync window 656..751, 800-clock line.
        wait_k(318);  chk("full_rgb_x317", 32'({red_f, green_f, blue_f}), 32'h00);
        wait_k(319);  chk("full_rgb_x318", 32'({red_f, green_f, blue_f}), 32'h15);
        wait_k(656);  chk("full_hsync_x655", 32'(hsync_f), 32'd1);
        wait_k(657);  chk("full_hsync_x656", 32'(hsync_f), 32'd0);
        wait_k(752);  chk("full_hsync_x751", 32'(hsync_f), 32'd0);
        wait_k(753);  chk("full_hsync_x752", 32'(hsync_f), 32'd1);
        chk("full_vsync_line0", 32'(vsync_f), 32'd1);
        wait_k(1456); chk("full_hsync_l1_x655", 32'(hsync_f), 32'd1);
        wait_k(1457); chk("full_hsync_l1_x656", 32'(hsync_f), 32'd0);

        // Mid-line reset: raster restarts at origin on the next cycle.
        wait_k(2000);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_hsync", 32'(hsync), 32'd1);
        chk("midreset_rgb", 32'({red, green, blue}), 32'd0);
        chk("midreset_k", 32'(k), 32'd0);
        rst = 1'b0;

        // Frame 0: reset positions shown, new inputs not yet visible.
        goto(0, 318, 0);  pix("f0_net_318_0", 6'h15);
        goto(0, 318, 16); pix("f0_nonet_318_16", 6'h00);
        goto(0, 100, 50); pix("f0_ball_hidden", 6'h00);
        goto(0, 0, VA);   chk("f0_tick", 32'(frame_tick), 32'd1);
        goto(0, 1, VA);   chk("f0_tick_off", 32'(frame_tick), 32'd0);
        goto(0, 0, 65);   chk("f0_vsync_65", 32'(vsync), 32'd1);
        goto(0, 0, 66);   chk("f0_vsync_66", 32'(vsync), 32'd0);
        goto(0, 0, 68);   chk("f0_vsync_68", 32'(vsync), 32'd1);

        // Frame 1: ball (100,50), player_y 0, opp_y 4, score 3A.
        goto(1, 20, 0);   pix("f1_player_20_0", 6'h0C);
        goto(1, 296, 16); pix("f1_glyph_A", GLYPH_ON);
`ifdef SCORE_DISPLAY_EN
        goto(1, 336, 16); pix("f1_glyph_3", 6'h3F);
`else
        goto(1, 336, 16); pix("f1_opp_336_16", 6'h30);
`endif
        goto(1, 0, 20);
        current_ball_x = 10'd347;
        current_ball_y = 10'd30;
        goto(1, 99, 50);  pix("f1_left_of_ball", 6'h00);
        goto(1, 100, 50); pix("f1_ball_100_50", 6'h3F);
        goto(1, 110, 50); pix("f1_right_of_ball", 6'h00);
        goto(1, 109, 59); pix("f1_ball_109_59", 6'h3F);
        goto(1, 30, 60);  pix("f1_not_player_30_60", 6'h00);
        goto(1, 339, 63); pix("f1_opp_339_63", 6'h30);

        // Frame 2: ball moved to the right edge, clipped to 5 columns.
        goto(2, 347, 30); pix("f2_ball_347_30", 6'h3F);
        goto(2, 346, 38); pix("f2_left_of_ball", 6'h00);
        goto(2, 351, 39); pix("f2_ball_351_39", 6'h3F);
        goto(2, 100, 50); pix("f2_old_ball_gone", 6'h00);
        goto(2, 5, VA);
        chk("tick_count", 32'(tick_count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
